// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-side memory arbiter: FSM states and bus word/address widths.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_arb_perf.sv
// Activity counters for memory_arbiter: served i/d responses and RAM-busy cycles.
// Latency: counts update on the edge after the event; no backpressure (observe-only), counters wrap.
module mem_arb_perf (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        resp_i,
    input  logic        resp_d,
    input  logic        stall,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stallcount
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount     <= '0;
            dcount     <= '0;
            stallcount <= '0;
        end else begin
            if (resp_i) icount     <= icount + 32'd1;
            if (resp_d) dcount     <= dcount + 32'd1;
            if (stall)  stallcount <= stallcount + 32'd1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction/data cache requests onto one single-ported RAM, data first with an i anti-starvation flag.
// Latency: request seen in IDLE, RAM strobes until ramrdy, one-cycle response after (min 3 cycles).
// Backpressure: requesters are held in wait until served; dropping/changing a request aborts it. Optional MEM_ARB_PERF_EN adds counters.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [DW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          dwait,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ramrdy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   icount,
    output logic [31:0]   dcount,
    output logic [31:0]   stallcount
`endif
);

    arb_state_t    state, state_nxt;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_wr;
    logic          req_d;
    logic          last_d;
    logic [DW-1:0] iload_q, dload_q;

    logic d_req, grant_d, grant_i, in_acc, abort;

    assign d_req   = dREN | dWEN;
    // A pending i request beats d only when the previous grant went to d.
    assign grant_d = d_req && !(last_d && iREN);
    assign grant_i = iREN && !grant_d;
    assign in_acc  = (state == IACC) || (state == DACC);

    always_comb begin
        abort = 1'b0;
        if (req_d)
            abort = !d_req || (daddr != req_addr) || (dWEN != req_wr) || (dstore != req_data);
        else
            abort = !iREN || (iaddr != req_addr);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = DACC;
                else if (grant_i) state_nxt = IACC;
            end
            IACC, DACC: begin
                ramREN   = !req_wr;
                ramWEN   = req_wr;
                ramaddr  = req_addr;
                ramstore = req_wr ? req_data : '0;
                if (abort)       state_nxt = IDLE;
                else if (ramrdy) state_nxt = RESP;
            end
            RESP: begin
                iwait     = req_d;
                dwait     = !req_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            req_d    <= 1'b0;
            last_d   <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            if (state == IDLE && (grant_d || grant_i)) begin
                req_d    <= grant_d;
                req_addr <= grant_d ? daddr : iaddr;
                req_data <= grant_d ? dstore : '0;
                req_wr   <= grant_d && dWEN;
                last_d   <= grant_d;
            end
            // Writes leave both load registers untouched.
            if (in_acc && !abort && ramrdy && !req_wr) begin
                if (req_d) dload_q <= ramload;
                else       iload_q <= ramload;
            end
        end
    end

    assign iload = iload_q;
    assign dload = dload_q;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .CLK        (CLK),
        .nRST       (nRST),
        .resp_i     (state == RESP && !req_d),
        .resp_d     (state == RESP && req_d),
        .stall      (in_acc),
        .icount     (icount),
        .dcount     (dcount),
        .stallcount (stallcount)
    );
`endif

endmodule
